// File: rtl/upcc_dec_if.sv
// Sample/report bus of the up/down code counter decoder.
// The producer drives inval/inea; the decoder drives the out* signals.
interface upcc_dec_if #(
  parameter int POSW = 8
);
  logic                   inval;
  logic [2:0]             inea;
  logic [2:0]             outidx;
  logic                   outdir;
  logic                   outmov;
  logic                   outerr;
  logic                   outlock;
  logic signed [POSW-1:0] outpos;
  logic [3:0]             outerrcnt;

  modport master (
    output inval, inea,
    input  outidx, outdir, outmov, outerr, outlock, outpos, outerrcnt
  );

  modport slave (
    input  inval, inea,
    output outidx, outdir, outmov, outerr, outlock, outpos, outerrcnt
  );
endinterface

// File: rtl/upcc_dec.sv
// Sequence decoder for the 3-bit up/down code counter state bus.
// Optional saturating error counter enabled by defining UPCC_ERRCNT_EN.
module upcc_dec #(
  parameter int POSW = 8
) (
  input  logic     clk,
  input  logic     rst,
  upcc_dec_if.slave bus
);

  typedef enum logic {UNLOCK, LOCK} state_t;

  state_t            state_q;
  logic [2:0]        idx_q;
  logic              dir_q;
  logic              mov_q;
  logic              err_q;
  logic [POSW-1:0]   pos_q;

  logic              code_ok;
  logic [2:0]        code_idx;
  logic [3:0]        fwd_sum;
  logic [2:0]        step;
  logic              err_event;

  // Code table lookup and forward distance (0..5) from the held index.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    code_ok  = 1'b1;
    code_idx = 3'd0;
    unique case (bus.inea)
      3'b100:  code_idx = 3'd0;
      3'b011:  code_idx = 3'd1;
      3'b101:  code_idx = 3'd2;
      3'b010:  code_idx = 3'd3;
      3'b111:  code_idx = 3'd4;
      3'b110:  code_idx = 3'd5;
      default: code_ok  = 1'b0;
    endcase
    fwd_sum = {1'b0, code_idx} + 4'd6 - {1'b0, idx_q};
    step    = (fwd_sum >= 4'd6) ? 3'(fwd_sum - 4'd6) : fwd_sum[2:0];
    // Illegal code anywhere, or a legal jump of 2..4 forward (2 or 3 either way) while locked.
    err_event = bus.inval &&
                (!code_ok || (state_q == LOCK && step != 3'd0 && step != 3'd1 && step != 3'd5));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCK;
      idx_q   <= 3'd0;
      dir_q   <= 1'b0;
      mov_q   <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      mov_q <= 1'b0;
      err_q <= err_event;
      if (bus.inval) begin
        unique case (state_q)
          UNLOCK: begin
            if (code_ok) begin
              idx_q   <= code_idx;
              state_q <= LOCK;
            end
          end
          LOCK: begin
            if (!code_ok) begin
              state_q <= UNLOCK;
            end else if (step == 3'd1) begin
              idx_q <= code_idx;
              dir_q <= 1'b1;
              mov_q <= 1'b1;
              pos_q <= pos_q + POSW'(1);
            end else if (step == 3'd5) begin
              idx_q <= code_idx;
              dir_q <= 1'b0;
              mov_q <= 1'b1;
              pos_q <= pos_q - POSW'(1);
            end else if (step != 3'd0) begin
              // Resync: adopt the new index without counting a move.
              idx_q <= code_idx;
            end
          end
          default: state_q <= UNLOCK;
        endcase
      end
    end
  end

`ifdef UPCC_ERRCNT_EN
  logic [3:0] errcnt_q;

  // Counts in the same edge that raises the error pulse, so both appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_q <= 4'd0;
    end else if (err_event && errcnt_q != 4'd15) begin
      errcnt_q <= errcnt_q + 4'd1;
    end
  end

  assign bus.outerrcnt = errcnt_q;
`else
  assign bus.outerrcnt = 4'd0;
`endif

  assign bus.outidx  = idx_q;
  assign bus.outdir  = dir_q;
  assign bus.outmov  = mov_q;
  assign bus.outerr  = err_q;
  assign bus.outlock = (state_q == LOCK);
  assign bus.outpos  = $signed(pos_q);

endmodule

// File: tb/tb_upcc_dec.sv
// Scoreboard bench for upcc_dec: stimulus pushes model predictions, a monitor pops and compares.
// Honours UPCC_ERRCNT_EN for the expected error count.
module tb_upcc_dec;
  localparam int POSW = 8;

  typedef struct packed {
    int              due;
    logic [2:0]      idx;
    logic            dir;
    logic            mov;
    logic            err;
    logic            lock;
    logic [POSW-1:0] pos;
    logic [3:0]      cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  upcc_dec_if #(.POSW(POSW)) bus ();

  upcc_dec #(.POSW(POSW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: table of codes in sequence order plus plain integer state.
  logic [2:0] code_tab [6] = '{3'b100, 3'b011, 3'b101, 3'b010, 3'b111, 3'b110};
  int m_idx = 0, m_pos = 0, m_cnt = 0;
  bit m_lock = 0, m_dir = 0, m_mov = 0, m_err = 0;

  function automatic int idx_of(logic [2:0] code);
    for (int i = 0; i < 6; i++)
      if (code_tab[i] == code) return i;
    return -1;
  endfunction

  task automatic model(bit v, logic [2:0] code, bit r);
    int ci, d;
    m_mov = 0;
    m_err = 0;
    if (r) begin
      m_idx = 0; m_pos = 0; m_cnt = 0; m_lock = 0; m_dir = 0;
    end else if (v) begin
      ci = idx_of(code);
      if (ci < 0) begin
        m_err  = 1;
        m_lock = 0;
      end else if (!m_lock) begin
        m_idx  = ci;
        m_lock = 1;
      end else begin
        d = ((ci - m_idx) % 6 + 6) % 6;
        if (d == 1) begin
          m_idx = ci; m_dir = 1; m_mov = 1; m_pos = m_pos + 1;
        end else if (d == 5) begin
          m_idx = ci; m_dir = 0; m_mov = 1; m_pos = m_pos - 1;
        end else if (d != 0) begin
          m_idx = ci; m_err = 1;
        end
      end
`ifdef UPCC_ERRCNT_EN
      if (m_err && m_cnt < 15) m_cnt = m_cnt + 1;
`endif
    end
  endtask

  task automatic drive(bit v, logic [2:0] code, bit r);
    exp_t e;
    @(posedge clk);
    #1;
    bus.inval = v;
    bus.inea  = code;
    rst       = r;
    model(v, code, r);
    e.due  = cyc + 1;
    e.idx  = 3'(m_idx);
    e.dir  = m_dir;
    e.mov  = m_mov;
    e.err  = m_err;
    e.lock = m_lock;
    e.pos  = POSW'(m_pos);
    e.cnt  = 4'(m_cnt);
    sb_q.push_back(e);
  endtask

  function automatic logic [2:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return {2'b00, 1'($urandom_range(0, 1))};
    else if (r <= 3) return code_tab[(m_idx + 1) % 6];
    else if (r <= 6) return code_tab[(m_idx + 5) % 6];
    else if (r == 7) return code_tab[m_idx];
    else             return code_tab[$urandom_range(0, 5)];
  endfunction

  // Monitor: compares the full output vector once its due cycle arrives.
  initial begin
    exp_t e;
    logic [18:0] got, want;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e    = sb_q.pop_front();
        got  = {bus.outidx, bus.outdir, bus.outmov, bus.outerr, bus.outlock,
                bus.outpos, bus.outerrcnt};
        want = {e.idx, e.dir, e.mov, e.err, e.lock, e.pos, e.cnt};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL out@cyc%0d: got idx=%0d dir=%b mov=%b err=%b lock=%b pos=%0d cnt=%0d, need idx=%0d dir=%b mov=%b err=%b lock=%b pos=%0d cnt=%0d",
                   cyc, bus.outidx, bus.outdir, bus.outmov, bus.outerr, bus.outlock,
                   bus.outpos, bus.outerrcnt, e.idx, e.dir, e.mov, e.err, e.lock,
                   $signed(e.pos), e.cnt);
        end
      end
    end
  end

  initial begin
    bus.inval = 1'b0;
    bus.inea  = 3'b000;

    drive(0, 3'b000, 1);
    drive(1, 3'b100, 1);
    // Lock then two up steps.
    drive(1, 3'b100, 0);
    drive(1, 3'b011, 0);
    drive(1, 3'b101, 0);
    // Down step wrapping 0 -> 5.
    drive(0, 3'b000, 1);
    drive(1, 3'b100, 0);
    drive(1, 3'b110, 0);
    // Skip of three steps -> resync, then an idle cycle.
    drive(0, 3'b000, 1);
    drive(1, 3'b100, 0);
    drive(1, 3'b010, 0);
    drive(0, 3'b111, 0);
    // Illegal code drops lock, next legal sample only relocks.
    drive(1, 3'b000, 0);
    drive(1, 3'b111, 0);
    drive(1, 3'b001, 0);
    drive(1, 3'b001, 0);
    drive(1, 3'b010, 0);
    // Positive wrap: 130 up steps from zero.
    drive(0, 3'b000, 1);
    drive(1, 3'b100, 0);
    for (int k = 0; k < 130; k++) drive(1, code_tab[(m_idx + 1) % 6], 0);
    // Negative wrap: 129 down steps from zero.
    drive(0, 3'b000, 1);
    drive(1, 3'b100, 0);
    for (int k = 0; k < 129; k++) drive(1, code_tab[(m_idx + 5) % 6], 0);
    // Randomised traffic with idle gaps and an occasional reset.
    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 3) != 0, rand_code(), $urandom_range(0, 199) == 0);
    // Error counter saturation, reset landing on the 17th illegal sample.
    for (int k = 0; k < 16; k++) drive(1, 3'b000, 0);
    drive(1, 3'b001, 1);
    drive(0, 3'b000, 0);
    drive(1, 3'b011, 0);
    drive(1, 3'b101, 0);
    drive(0, 3'b000, 0);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #3;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, need 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/upcc_dec.md
# upcc_dec

Sequence decoder for the 3-bit up/down code counter state bus (`inea`). It samples the code stream produced by the counter's next-state logic and state register, and reports:
- the recovered step index;
- the direction of the last move;
- a signed net position;
- illegal codes and skipped steps.

It sits on the consumer side of the counter state bus, for example in front of a display driver or a position monitor.

## Interface
- `POSW`, default 8: width of the signed position accumulator, two's complement.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `inval` input, 1 bit: `inea` holds a sample to decode this cycle.
- `inea` input, 3 bits: counter state code.
- `outidx` output, 3 bits: decoded index, 0..5.
- `outdir` output, 1 bit: direction of the last legal move; 1 = up (`inup=1`), 0 = down.
- `outmov` output, 1 bit: one-cycle pulse on each legal single-step move.
- `outerr` output, 1 bit: one-cycle pulse on an illegal code or a skipped step.
- `outlock` output, 1 bit: decoder is synchronised to the sequence.
- `outpos` output, `POSW` bits: signed net position (up steps minus down steps).
- `outerrcnt` output, 4 bits: saturating error count; see Configuration.

## Operation
- Code table (index: code `inea[2:0]`):
  - 0: 100
  - 1: 011
  - 2: 101
  - 3: 010
  - 4: 111
  - 5: 110
- An up step is idx → (idx+1) mod 6; a down step is idx → (idx+5) mod 6.
- Codes 000 and 001 are illegal.
- FSM has two states, UNLOCK and LOCK. Reset state is UNLOCK.
- UNLOCK, `inval=1`:
  - legal code → load `outidx`, go to LOCK, `outlock=1`. No `outmov`; `outpos` unchanged.
  - illegal code → `outerr` pulse, stay in UNLOCK.
- LOCK, `inval=1`:
  - same code as `outidx` → hold, no pulse.
  - up step → `outidx`+1 mod 6, `outdir=1`, `outmov` pulse, `outpos`+1.
  - down step → `outidx`-1 mod 6, `outdir=0`, `outmov` pulse, `outpos`-1.
  - legal code 2 or 3 steps away → `outerr` pulse, resync: load the new index, stay in LOCK. `outdir` and `outpos` unchanged.
  - illegal code → `outerr` pulse, go to UNLOCK, `outlock=0`. `outidx` and `outpos` hold.
- `inval=0`: all registers hold; `outmov` and `outerr` are 0.
- `outpos` wraps modulo 2^`POSW`: 127+1 → -128, and -128-1 → 127 (for `POSW`=8).
- Reset values: `outidx`=0, `outdir`=0, `outmov`=0, `outerr`=0, `outlock`=0, `outpos`=0, `outerrcnt`=0.
- `rst` takes priority over `inval` in the same cycle. Reset mid-sequence discards lock, so the next valid sample only relocks and does not move.

## Timing
- All outputs are registered.
- A sample taken at rising edge N (`inval=1`) is reflected on the outputs in the cycle after edge N.
- Latency is 1 cycle. Throughput is one sample per cycle.
- `outmov` and `outerr` are high for exactly one cycle per event. They never assert together.
- Back-to-back samples each cycle are decoded independently against the index updated by the previous edge.
- `rst` is sampled only at rising edges. All outputs take reset values after that edge.

## Configuration
- `UPCC_ERRCNT_EN` defined:
  - 4-bit error counter increments on every `outerr` pulse;
  - saturates at 15;
  - is cleared only by `rst`;
  - drives `outerrcnt`.
- `UPCC_ERRCNT_EN` undefined: no counter logic; `outerrcnt` is tied to 0.

## Test plan
- Reset, then samples 100, 011, 101: lock on the first sample (`outidx`=0, `outpos`=0), then two `outmov` pulses. Ends with `outidx`=2, `outdir`=1, `outpos`=2.
- Locked at 100, sample 110: `outidx`=5, `outdir`=0, `outpos`=-1, one `outmov` pulse.
- Locked at 100, sample 010: `outerr` pulse, `outidx`=3, `outlock`=1, `outpos` unchanged.
- Locked, sample 000: `outerr` pulse, `outlock`=0. Then sample 111: relock with `outidx`=4 and no `outmov`.
- 130 consecutive up steps from `outpos`=0: `outpos` reads 127 after 127 steps, then -128, then -126 after the last step.
- With `UPCC_ERRCNT_EN`: 17 illegal samples → `outerrcnt`=15. Assert `rst` on the 17th sample cycle → all outputs take reset values the next cycle. Without the macro, `outerrcnt` stays 0 throughout.
